// File: rtl/acc_ser_pkg.sv
// Shared constants for the accumulator serial transmitter: FSM state codes,
// line levels and default geometry. Parity frames are enabled by ACC_SER_PARITY_EN.
package acc_ser_pkg;

  localparam int DEF_W   = 16;
  localparam int DEF_DIV = 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

`ifdef ACC_SER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

endpackage

// File: rtl/acc_ser_if.sv
// Frame request / serial line bundle between the accumulator side (master)
// and the serial transmitter (slave).
interface acc_ser_if #(
  parameter int W = acc_ser_pkg::DEF_W
);
  logic [W-1:0] a;
  logic         start;
  logic         sout;
  logic         busy;
  logic         done;

  modport master (output a, start, input sout, busy, done);
  modport slave  (input a, start, output sout, busy, done);
endinterface

// File: rtl/acc_ser_baud_tick.sv
// Baud divider: free-running counter that pulses tick every DIV cycles;
// clr restarts the count so the first bit of a frame is full length.
module baud_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_b,
  input  logic clr,
  output logic tick
);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] cnt;

  assign tick = (cnt == DW'(DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/acc_ser_tx.sv
// Snapshots the accumulator on a start request and sends it as one serial frame:
// start bit, W data bits MSB first, optional even parity (ACC_SER_PARITY_EN), stop bit.
module acc_ser_tx
  import acc_ser_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int DIV = DEF_DIV
) (
  input  logic       clk,
  input  logic       rst_b,
  acc_ser_if.slave   bus
);
  localparam int BW = $clog2(W + 1);

  logic [2:0]    state;
  logic [W-1:0]  shreg;
  logic [BW-1:0] bit_cnt;
  logic          sout_q;
  logic          busy_q;
  logic          done_q;
  logic          accept;
  logic          tick;
`ifdef ACC_SER_PARITY_EN
  logic          par;
`endif

  // Only an idle transmitter takes a request; requests while busy are dropped.
  assign accept = (state == IDLE) && bus.start;

  baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (accept),
    .tick  (tick)
  );

  assign bus.sout = sout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      sout_q  <= IDLE_LVL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ACC_SER_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      // NOTE: default-low here makes done a single-cycle pulse without extra clearing logic.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg   <= bus.a;
            bit_cnt <= '0;
            state   <= START;
            busy_q  <= 1'b1;
            sout_q  <= START_LVL;
`ifdef ACC_SER_PARITY_EN
            par     <= ^bus.a;
`endif
          end
        end
        START: begin
          if (tick) begin
            state  <= DATA;
            sout_q <= shreg[W-1];
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= {shreg[W-2:0], 1'b0};
            if (bit_cnt == BW'(W - 1)) begin
              bit_cnt <= '0;
`ifdef ACC_SER_PARITY_EN
              state   <= PARITY;
              sout_q  <= par;
`else
              state   <= STOP;
              sout_q  <= IDLE_LVL;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sout_q  <= shreg[W-2];
            end
          end
        end
`ifdef ACC_SER_PARITY_EN
        PARITY: begin
          if (tick) begin
            state  <= STOP;
            sout_q <= IDLE_LVL;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          sout_q <= IDLE_LVL;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_ser_tx.sv
// Scoreboard bench for acc_ser_tx: a DIV=1 and a DIV=4 instance, expected frame
// values queued at request time and compared sample-by-sample against sout.
module tb_acc_ser_tx;
  localparam int W = 16;
`ifdef ACC_SER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = W + 2 + P;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  acc_ser_if #(.W(W)) if1 ();
  acc_ser_if #(.W(W)) if4 ();

  acc_ser_tx #(.W(W), .DIV(1)) dut1 (.clk(clk), .rst_b(rst_b), .bus(if1));
  acc_ser_tx #(.W(W), .DIV(4)) dut4 (.clk(clk), .rst_b(rst_b), .bus(if4));

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp1_q[$];
  logic [W-1:0] exp4_q[$];

  logic [127:0] cap_vec, exp_vec;
  int           cap_len, exp_len;
  int           cap_gap, cap_done_in_busy;
  logic         cap_done_after, cap_sout_after;
  bit           cap_timeout;

  // Expected line samples: start, data MSB first, [even parity], stop; each bit held div cycles.
  task automatic build_stream(input logic [W-1:0] v, input int div);
    exp_vec = '0;
    exp_len = 0;
    for (int i = 0; i < div; i++) begin exp_vec = {exp_vec[126:0], 1'b0}; exp_len++; end
    for (int b = W - 1; b >= 0; b--)
      for (int i = 0; i < div; i++) begin exp_vec = {exp_vec[126:0], v[b]}; exp_len++; end
    if (P == 1)
      for (int i = 0; i < div; i++) begin exp_vec = {exp_vec[126:0], ^v}; exp_len++; end
    for (int i = 0; i < div; i++) begin exp_vec = {exp_vec[126:0], 1'b1}; exp_len++; end
  endtask

  // Waits for busy, records sout every cycle while busy, then samples the cycle after.
  task automatic capture(input int sel, input bit release_start);
    cap_vec = '0; cap_len = 0; cap_gap = 0; cap_done_in_busy = 0;
    cap_timeout = 1'b0; cap_done_after = 1'bx; cap_sout_after = 1'bx;
    @(negedge clk);
    while (((sel == 1) ? if4.busy : if1.busy) !== 1'b1 && cap_gap < 20) begin
      cap_gap++;
      @(negedge clk);
    end
    if (cap_gap >= 20) begin
      cap_timeout = 1'b1;
    end else begin
      if (release_start) begin
        if (sel == 1) if4.start = 1'b0; else if1.start = 1'b0;
      end
      while (((sel == 1) ? if4.busy : if1.busy) === 1'b1 && cap_len < 400) begin
        cap_vec = {cap_vec[126:0], ((sel == 1) ? if4.sout : if1.sout)};
        if (((sel == 1) ? if4.done : if1.done) !== 1'b0) cap_done_in_busy++;
        cap_len++;
        @(negedge clk);
      end
      if (cap_len >= 400) cap_timeout = 1'b1;
      cap_done_after = (sel == 1) ? if4.done : if1.done;
      cap_sout_after = (sel == 1) ? if4.sout : if1.sout;
    end
  endtask

  task automatic test_reset;
    rst_b = 1'b0;
    if1.start = 1'b0; if1.a = '0;
    if4.start = 1'b0; if4.a = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({if1.sout, if1.busy, if1.done} !== 3'b100) begin
      errors++; $display("FAIL reset_dut1: sout/busy/done got %b required 100", {if1.sout, if1.busy, if1.done});
    end
    checks++;
    if ({if4.sout, if4.busy, if4.done} !== 3'b100) begin
      errors++; $display("FAIL reset_dut4: sout/busy/done got %b required 100", {if4.sout, if4.busy, if4.done});
    end
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({if1.sout, if1.busy, if1.done} !== 3'b100) begin
      errors++; $display("FAIL idle_after_reset: sout/busy/done got %b required 100", {if1.sout, if1.busy, if1.done});
    end
  endtask

  task automatic test_basic;
    logic [W-1:0] v;
    if1.a = 16'h2710; if1.start = 1'b1;
    exp1_q.push_back(16'h2710);
    capture(0, 1'b1);
    v = (exp1_q.size() > 0) ? exp1_q.pop_front() : 'x;
    build_stream(v, 1);
    checks++;
    if (cap_timeout) begin errors++; $display("FAIL basic_timeout: frame did not complete, got %0d busy cycles", cap_len); end
    checks++;
    if (cap_len != NB) begin errors++; $display("FAIL basic_busy_len: got %0d cycles required %0d", cap_len, NB); end
    checks++;
    if (cap_len != exp_len || cap_vec !== exp_vec) begin
      errors++; $display("FAIL basic_stream: got %0d samples %h required %0d samples %h", cap_len, cap_vec, exp_len, exp_vec);
    end
    checks++;
    if (cap_done_after !== 1'b1 || cap_done_in_busy != 0) begin
      errors++; $display("FAIL basic_done: done after frame got %b required 1, done during frame got %0d required 0", cap_done_after, cap_done_in_busy);
    end
    checks++;
    if (cap_sout_after !== 1'b1) begin errors++; $display("FAIL basic_idle_line: got %b required 1", cap_sout_after); end
    @(negedge clk);
    checks++;
    if (if1.done !== 1'b0 || if1.busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: done/busy got %b%b required 00", if1.done, if1.busy);
    end
  endtask

  task automatic test_div4;
    logic [W-1:0] v;
    if4.a = 16'h8001; if4.start = 1'b1;
    exp4_q.push_back(16'h8001);
    capture(1, 1'b1);
    v = (exp4_q.size() > 0) ? exp4_q.pop_front() : 'x;
    build_stream(v, 4);
    checks++;
    if (cap_len != NB * 4) begin errors++; $display("FAIL div4_busy_len: got %0d cycles required %0d", cap_len, NB * 4); end
    checks++;
    if (cap_len != exp_len || cap_vec !== exp_vec) begin
      errors++; $display("FAIL div4_stream: got %0d samples %h required %0d samples %h", cap_len, cap_vec, exp_len, exp_vec);
    end
    checks++;
    if (cap_done_after !== 1'b1 || cap_done_in_busy != 0 || cap_sout_after !== 1'b1) begin
      errors++; $display("FAIL div4_done: done_after=%b sout_after=%b done_in_busy=%0d required 1 1 0", cap_done_after, cap_sout_after, cap_done_in_busy);
    end
  endtask

  task automatic test_ignore_mid_frame;
    logic [W-1:0] v;
    int extra_busy;
    if1.a = 16'h2710; if1.start = 1'b1;
    exp1_q.push_back(16'h2710);
    fork
      capture(0, 1'b1);
      begin
        repeat (6) @(negedge clk);
        if1.start = 1'b1; if1.a = 16'hFFFF;
        repeat (3) @(negedge clk);
        if1.start = 1'b0;
      end
    join
    v = (exp1_q.size() > 0) ? exp1_q.pop_front() : 'x;
    build_stream(v, 1);
    checks++;
    if (cap_len != exp_len || cap_vec !== exp_vec) begin
      errors++; $display("FAIL ignore_stream: got %0d samples %h required %0d samples %h", cap_len, cap_vec, exp_len, exp_vec);
    end
    extra_busy = 0;
    repeat (NB) begin
      @(negedge clk);
      if (if1.busy !== 1'b0) extra_busy++;
    end
    checks++;
    if (extra_busy != 0) begin errors++; $display("FAIL ignore_no_queue: busy cycles after frame got %0d required 0", extra_busy); end
  endtask

  task automatic test_reset_mid_frame;
    logic [W-1:0] v;
    int stray;
    if1.a = 16'h2710; if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (if1.busy !== 1'b1 || if1.sout !== 1'b1) begin
      errors++; $display("FAIL reset_mid_bit5: busy/sout got %b%b required 11", if1.busy, if1.sout);
    end
    rst_b = 1'b0;
    #1;
    checks++;
    if ({if1.sout, if1.busy, if1.done} !== 3'b100) begin
      errors++; $display("FAIL reset_mid_abort: sout/busy/done got %b required 100", {if1.sout, if1.busy, if1.done});
    end
    @(negedge clk);
    rst_b = 1'b1;
    stray = 0;
    repeat (NB) begin
      @(negedge clk);
      if (if1.done !== 1'b0 || if1.busy !== 1'b0 || if1.sout !== 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL reset_mid_quiet: non-idle cycles after abort got %0d required 0", stray); end
    if1.a = 16'h2710; if1.start = 1'b1;
    exp1_q.push_back(16'h2710);
    capture(0, 1'b1);
    v = (exp1_q.size() > 0) ? exp1_q.pop_front() : 'x;
    build_stream(v, 1);
    checks++;
    if (cap_len != exp_len || cap_vec !== exp_vec || cap_done_after !== 1'b1) begin
      errors++; $display("FAIL reset_mid_resend: got %0d samples %h done %b required %0d samples %h done 1", cap_len, cap_vec, cap_done_after, exp_len, exp_vec);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] v;
    int extra_busy;
    if1.a = 16'h2710; if1.start = 1'b1;
    for (int f = 0; f < 3; f++) exp1_q.push_back(16'h2710);
    for (int f = 0; f < 3; f++) begin
      capture(0, f == 2);
      v = (exp1_q.size() > 0) ? exp1_q.pop_front() : 'x;
      build_stream(v, 1);
      checks++;
      if (cap_gap != 0) begin errors++; $display("FAIL b2b_gap[%0d]: idle cycles before busy got %0d required 0", f, cap_gap); end
      checks++;
      if (cap_len != exp_len || cap_vec !== exp_vec) begin
        errors++; $display("FAIL b2b_stream[%0d]: got %0d samples %h required %0d samples %h", f, cap_len, cap_vec, exp_len, exp_vec);
      end
      checks++;
      if (cap_done_after !== 1'b1 || cap_sout_after !== 1'b1) begin
        errors++; $display("FAIL b2b_idle[%0d]: done/sout in gap cycle got %b%b required 11", f, cap_done_after, cap_sout_after);
      end
    end
    extra_busy = 0;
    repeat (NB) begin
      @(negedge clk);
      if (if1.busy !== 1'b0) extra_busy++;
    end
    checks++;
    if (extra_busy != 0) begin errors++; $display("FAIL b2b_stop: busy cycles after release got %0d required 0", extra_busy); end
    checks++;
    if (exp1_q.size() != 0 || exp4_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: leftover entries got %0d required 0", exp1_q.size() + exp4_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div4();
    test_ignore_mid_frame();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
